watch_time_setter: RTL and testbench

Button-driven time editor for the watch, and the producer side of the `bin_time`/`set_time` load interface of the timekeeper. It snapshots the running time on request and lets the user step through fields, incrementing or decrementing each with calendar-correct wrap. On commit it delivers a validated packed time word with a one-cycle `set_time` strobe. It sits between the debounced button logic and the timekeeper.

---
 rtl/watch_time_setter_pkg.sv | 46 ++++
 rtl/watch_time_setter_days_in_month.sv | 23 ++
 rtl/watch_time_setter.sv | 222 ++++++++++++++++++++++
 tb/tb_watch_time_setter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/watch_time_setter_pkg.sv
// Shared definitions for the watch time editor: field codes, FSM states,
// packed time word layout and the power-on time.
package watch_time_setter_pkg;

   localparam logic [2:0] FLD_YEAR   = 3'd0;
   localparam logic [2:0] FLD_MONTH  = 3'd1;
   localparam logic [2:0] FLD_DAY    = 3'd2;
   localparam logic [2:0] FLD_HOUR   = 3'd3;
   localparam logic [2:0] FLD_MINUTE = 3'd4;
   localparam logic [2:0] FLD_SECOND = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT   = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   localparam int TIME_W     = 52;
   localparam int YEAR_W     = 12;
   localparam int UNIT_W     = 8;
   localparam int YEAR_OFS   = 40;
   localparam int MONTH_OFS  = 32;
   localparam int DAY_OFS    = 24;
   localparam int HOUR_OFS   = 16;
   localparam int MINUTE_OFS = 8;
   localparam int SECOND_OFS = 0;

   localparam logic [11:0] RST_YEAR   = 12'd2021;
   localparam logic [7:0]  RST_MONTH  = 8'd5;
   localparam logic [7:0]  RST_DAY    = 8'd30;
   localparam logic [7:0]  RST_HOUR   = 8'd18;
   localparam logic [7:0]  RST_MINUTE = 8'd32;
   localparam logic [7:0]  RST_SECOND = 8'd0;

   function automatic logic [TIME_W-1:0] pack_time(
      input logic [11:0] year,
      input logic [7:0]  month,
      input logic [7:0]  day,
      input logic [7:0]  hour,
      input logic [7:0]  minute,
      input logic [7:0]  second
   );
      return {year, month, day, hour, minute, second};
   endfunction

endpackage

// File: rtl/watch_time_setter_days_in_month.sv
// Number of days in a given month of a given year (Gregorian leap rule).
module days_in_month
   import watch_time_setter_pkg::*;
(
   input  logic [11:0] year_i,
   input  logic [7:0]  month_i,
   output logic [4:0]  max_date_o
);

   logic leap_s;

   // month length lookup with February depending on the leap rule
   always_comb begin
      leap_s = (((year_i % 12'd4) == 12'd0) && ((year_i % 12'd100) != 12'd0))
               || ((year_i % 12'd400) == 12'd0);
      case (month_i)
         8'd2:                      max_date_o = leap_s ? 5'd29 : 5'd28;
         8'd4, 8'd6, 8'd9, 8'd11:   max_date_o = 5'd30;
         default:                   max_date_o = 5'd31;
      endcase
   end

endmodule

// File: rtl/watch_time_setter.sv
// Button-driven time editor: snapshots the running time, edits fields with
// calendar-correct wrap, and delivers the result with a one-cycle set_time.
module watch_time_setter
   import watch_time_setter_pkg::*;
#(
   parameter int unsigned TIMEOUT = 500_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] cur_year,
   input  logic [7:0]  cur_month,
   input  logic [7:0]  cur_day,
   input  logic [7:0]  cur_hour,
   input  logic [7:0]  cur_minute,
   input  logic [7:0]  cur_second,
   input  logic        btn_mode,
   input  logic        btn_sel,
   input  logic        btn_up,
   input  logic        btn_down,
   output logic [51:0] bin_time,
   output logic        set_time,
   output logic        editing,
   output logic [2:0]  field
);

   localparam logic [31:0] CNT_LAST = 32'(TIMEOUT - 32'd1);

   state_e      state_q;
   logic [31:0] cnt_q;
   logic        set_time_q;
   logic        editing_q;
   logic [2:0]  field_q;
   logic [11:0] year_q,   year_d;
   logic [7:0]  month_q,  month_d;
   logic [7:0]  day_q,    day_d;
   logic [7:0]  hour_q,   hour_d;
   logic [7:0]  minute_q, minute_d;
   logic [7:0]  second_q, second_d;

   logic        capture_s;
   logic        edit_up_s;
   logic        edit_dn_s;
   logic [4:0]  dim_cur_s;
   logic [4:0]  dim_new_s;
   logic [7:0]  dim_cur_ext_s;
   logic [7:0]  dim_new_ext_s;

   // Button priority inside EDIT is mode > sel > up > down.
   assign capture_s = (state_q == ST_IDLE) && btn_mode;
   assign edit_up_s = (state_q == ST_EDIT) && !btn_mode && !btn_sel && btn_up;
   assign edit_dn_s = (state_q == ST_EDIT) && !btn_mode && !btn_sel && !btn_up && btn_down;
   assign dim_cur_ext_s = {3'd0, dim_cur_s};
   assign dim_new_ext_s = {3'd0, dim_new_s};

   days_in_month u_dim_cur (
      .year_i     (year_q),
      .month_i    (month_q),
      .max_date_o (dim_cur_s)
   );

   // Evaluated on the post-update year/month so day can be clamped in the same cycle.
   days_in_month u_dim_new (
      .year_i     (year_d),
      .month_i    (month_d),
      .max_date_o (dim_new_s)
   );

   // next year and month: sanitised capture or wrapping step
   always_comb begin
      year_d  = year_q;
      month_d = month_q;
      if (capture_s) begin
         year_d  = (cur_year == 12'd0) ? 12'd1 : cur_year;
         month_d = ((cur_month == 8'd0) || (cur_month > 8'd12)) ? 8'd1 : cur_month;
      end else if (edit_up_s || edit_dn_s) begin
         case (field_q)
            FLD_YEAR: begin
               if (edit_up_s) begin
                  year_d = (year_q == 12'd4095) ? 12'd1 : year_q + 12'd1;
               end else begin
                  year_d = (year_q <= 12'd1) ? 12'd4095 : year_q - 12'd1;
               end
            end
            FLD_MONTH: begin
               if (edit_up_s) begin
                  month_d = (month_q >= 8'd12) ? 8'd1 : month_q + 8'd1;
               end else begin
                  month_d = (month_q <= 8'd1) ? 8'd12 : month_q - 8'd1;
               end
            end
            default: begin
               year_d  = year_q;
               month_d = month_q;
            end
         endcase
      end else begin
         year_d  = year_q;
         month_d = month_q;
      end
   end

   // next day/hour/minute/second; day is always clamped to the new month length
   always_comb begin
      day_d    = (day_q > dim_new_ext_s) ? dim_new_ext_s : day_q;
      hour_d   = hour_q;
      minute_d = minute_q;
      second_d = second_q;
      if (capture_s) begin
         if (cur_day == 8'd0) begin
            day_d = 8'd1;
         end else begin
            day_d = (cur_day > dim_new_ext_s) ? dim_new_ext_s : cur_day;
         end
         hour_d   = (cur_hour   >= 8'd24) ? 8'd0 : cur_hour;
         minute_d = (cur_minute >= 8'd60) ? 8'd0 : cur_minute;
         second_d = (cur_second >= 8'd60) ? 8'd0 : cur_second;
      end else if (edit_up_s || edit_dn_s) begin
         case (field_q)
            FLD_DAY: begin
               if (edit_up_s) begin
                  day_d = (day_q >= dim_cur_ext_s) ? 8'd1 : day_q + 8'd1;
               end else begin
                  day_d = (day_q <= 8'd1) ? dim_cur_ext_s : day_q - 8'd1;
               end
            end
            FLD_HOUR: begin
               if (edit_up_s) begin
                  hour_d = (hour_q >= 8'd23) ? 8'd0 : hour_q + 8'd1;
               end else begin
                  hour_d = (hour_q == 8'd0) ? 8'd23 : hour_q - 8'd1;
               end
            end
            FLD_MINUTE: begin
               if (edit_up_s) begin
                  minute_d = (minute_q >= 8'd59) ? 8'd0 : minute_q + 8'd1;
               end else begin
                  minute_d = (minute_q == 8'd0) ? 8'd59 : minute_q - 8'd1;
               end
            end
            FLD_SECOND: begin
               if (edit_up_s) begin
                  second_d = (second_q >= 8'd59) ? 8'd0 : second_q + 8'd1;
               end else begin
                  second_d = (second_q == 8'd0) ? 8'd59 : second_q - 8'd1;
               end
            end
            default: begin
               hour_d = hour_q;
            end
         endcase
      end else begin
         hour_d = hour_q;
      end
   end

   // control FSM with registered outputs and the edit registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 32'd0;
         set_time_q <= 1'b0;
         editing_q  <= 1'b0;
         field_q    <= FLD_YEAR;
         year_q     <= RST_YEAR;
         month_q    <= RST_MONTH;
         day_q      <= RST_DAY;
         hour_q     <= RST_HOUR;
         minute_q   <= RST_MINUTE;
         second_q   <= RST_SECOND;
      end else begin
         set_time_q <= 1'b0;
         year_q     <= year_d;
         month_q    <= month_d;
         day_q      <= day_d;
         hour_q     <= hour_d;
         minute_q   <= minute_d;
         second_q   <= second_d;
         case (state_q)
            ST_IDLE: begin
               if (btn_mode) begin
                  state_q   <= ST_EDIT;
                  editing_q <= 1'b1;
                  field_q   <= FLD_YEAR;
                  cnt_q     <= 32'd0;
               end
            end
            ST_EDIT: begin
               if (btn_mode) begin
                  state_q    <= ST_COMMIT;
                  editing_q  <= 1'b0;
                  set_time_q <= 1'b1;
                  cnt_q      <= 32'd0;
               end else if (btn_sel) begin
                  field_q <= (field_q >= FLD_SECOND) ? FLD_YEAR : field_q + 3'd1;
                  cnt_q   <= 32'd0;
               end else if (btn_up || btn_down) begin
                  cnt_q <= 32'd0;
               end else if (cnt_q >= CNT_LAST) begin
                  state_q   <= ST_IDLE;
                  editing_q <= 1'b0;
                  cnt_q     <= 32'd0;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            ST_COMMIT: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q   <= ST_IDLE;
               editing_q <= 1'b0;
            end
         endcase
      end
   end

   assign set_time = set_time_q;
   assign editing  = editing_q;
   assign field    = field_q;
   assign bin_time = pack_time(year_q, month_q, day_q, hour_q, minute_q, second_q);

endmodule

// File: tb/tb_watch_time_setter.sv
// Randomised and directed bench for watch_time_setter against a calendar-level reference model.
module tb_watch_time_setter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] cur_year = 12'd0;
   logic [7:0]  cur_month = 8'd0, cur_day = 8'd0, cur_hour = 8'd0;
   logic [7:0]  cur_minute = 8'd0, cur_second = 8'd0;
   logic        btn_mode = 1'b0, btn_sel = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic [51:0] bin_time;
   logic        set_time, editing;
   logic [2:0]  field;

   int n_checks = 0;
   int n_err = 0;

   // reference model state: 0 idle, 1 edit, 2 commit
   int m_st, my, mmo, md, mh, mmi, ms, mfld, mcnt;
   bit mset;

   watch_time_setter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
      .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
      .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_up(btn_up), .btn_down(btn_down),
      .bin_time(bin_time), .set_time(set_time), .editing(editing), .field(field)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int dim(input int y, input int mo);
      bit lp;
      lp = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
      if (mo == 2) return lp ? 29 : 28;
      if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
      return 31;
   endfunction

   function automatic logic [51:0] exp_word();
      return {12'(my), 8'(mmo), 8'(md), 8'(mh), 8'(mmi), 8'(ms)};
   endfunction

   task automatic model_reset();
      m_st = 0; mset = 0; mfld = 0; mcnt = 0;
      my = 2021; mmo = 5; md = 30; mh = 18; mmi = 32; ms = 0;
   endtask

   task automatic model_apply(input int dl);
      case (mfld)
         0: my  = (my - 1 + dl + 4095) % 4095 + 1;
         1: mmo = (mmo - 1 + dl + 12) % 12 + 1;
         2: md  = (md - 1 + dl + dim(my, mmo)) % dim(my, mmo) + 1;
         3: mh  = (mh + dl + 24) % 24;
         4: mmi = (mmi + dl + 60) % 60;
         default: ms = (ms + dl + 60) % 60;
      endcase
      if (md > dim(my, mmo)) md = dim(my, mmo);
   endtask

   task automatic model_step(input bit m, input bit s, input bit u, input bit d);
      mset = 0;
      case (m_st)
         0: if (m) begin
               my  = int'(cur_year);   if (my == 0) my = 1;
               mmo = int'(cur_month);  if (mmo < 1 || mmo > 12) mmo = 1;
               md  = int'(cur_day);    if (md < 1) md = 1;
               if (md > dim(my, mmo)) md = dim(my, mmo);
               mh  = int'(cur_hour);   if (mh >= 24) mh = 0;
               mmi = int'(cur_minute); if (mmi >= 60) mmi = 0;
               ms  = int'(cur_second); if (ms >= 60) ms = 0;
               mfld = 0; mcnt = 0; m_st = 1;
            end
         1: if (m) begin
               m_st = 2; mset = 1;
            end else if (s) begin
               mfld = (mfld + 1) % 6; mcnt = 0;
            end else if (u || d) begin
               model_apply(u ? 1 : -1); mcnt = 0;
            end else if (mcnt == TO - 1) begin
               m_st = 0; mcnt = 0;
            end else begin
               mcnt++;
            end
         default: m_st = 0;
      endcase
   endtask

   task automatic compare_all();
      check("editing", {63'd0, editing}, {63'd0, (m_st == 1)});
      check("field", {61'd0, field}, 64'(mfld));
      check("set_time", {63'd0, set_time}, {63'd0, mset});
      check("bin_time", {12'd0, bin_time}, {12'd0, exp_word()});
   endtask

   task automatic cycle(input bit m, input bit s, input bit u, input bit d);
      btn_mode = m; btn_sel = s; btn_up = u; btn_down = d;
      @(posedge clk);
      model_step(m, s, u, d);
      #1;
      compare_all();
      btn_mode = 1'b0; btn_sel = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
   endtask

   task automatic set_cur(input int y, input int mo, input int d, input int h, input int mi, input int s);
      cur_year = 12'(y); cur_month = 8'(mo); cur_day = 8'(d);
      cur_hour = 8'(h); cur_minute = 8'(mi); cur_second = 8'(s);
   endtask

   task automatic enter(input int y, input int mo, input int d, input int h, input int mi, input int s);
      set_cur(y, mo, d, h, mi, s);
      cycle(1, 0, 0, 0);
   endtask

   task automatic leave();
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      #12;
      check("rst_word", {12'd0, bin_time}, {12'd0, 12'd2021, 8'd5, 8'd30, 8'd18, 8'd32, 8'd0});
      check("rst_editing", {63'd0, editing}, 64'd0);
      check("rst_set_time", {63'd0, set_time}, 64'd0);
      check("rst_field", {61'd0, field}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // entry snapshot and immediate commit
      enter(2021, 5, 30, 18, 32, 7);
      check("enter_editing", {63'd0, editing}, 64'd1);
      check("enter_word", {12'd0, bin_time}, {12'd0, 12'd2021, 8'd5, 8'd30, 8'd18, 8'd32, 8'd7});
      cycle(1, 0, 0, 0);
      check("commit_strobe", {63'd0, set_time}, 64'd1);
      check("commit_word", {12'd0, bin_time}, {12'd0, 12'd2021, 8'd5, 8'd30, 8'd18, 8'd32, 8'd7});
      cycle(0, 0, 0, 0);
      check("strobe_single", {63'd0, set_time}, 64'd0);

      // wrap at both ends of every field
      enter(4095, 1, 1, 23, 0, 59);
      cycle(0, 0, 1, 0); check("year_up_wrap", 64'(bin_time[51:40]), 64'd1);
      cycle(0, 0, 0, 1); check("year_dn_wrap", 64'(bin_time[51:40]), 64'd4095);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 1); check("month_dn_wrap", 64'(bin_time[39:32]), 64'd12);
      cycle(0, 0, 1, 0); check("month_up_wrap", 64'(bin_time[39:32]), 64'd1);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 1); check("day_dn_wrap", 64'(bin_time[31:24]), 64'd31);
      cycle(0, 0, 1, 0); check("day_up_wrap", 64'(bin_time[31:24]), 64'd1);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 1, 0); check("hour_up_wrap", 64'(bin_time[23:16]), 64'd0);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 1); check("minute_dn_wrap", 64'(bin_time[15:8]), 64'd59);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 1, 0); check("second_up_wrap", 64'(bin_time[7:0]), 64'd0);
      leave();

      // leap-year day wrap and month-change clamps
      enter(2024, 2, 29, 0, 0, 0); cycle(0, 1, 0, 0); cycle(0, 1, 0, 0);
      cycle(0, 0, 1, 0); check("leap_day_up", 64'(bin_time[31:24]), 64'd1);
      leave();
      enter(2100, 2, 1, 0, 0, 0); cycle(0, 1, 0, 0); cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 1); check("c2100_day_dn", 64'(bin_time[31:24]), 64'd28);
      leave();
      enter(2000, 1, 31, 0, 0, 0); cycle(0, 1, 0, 0);
      cycle(0, 0, 1, 0); check("clamp_2000", 64'(bin_time[39:24]), 64'h021d);
      leave();
      enter(2023, 3, 31, 0, 0, 0); cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 1); check("clamp_2023", 64'(bin_time[39:24]), 64'h021c);
      leave();

      // sanitising out-of-range snapshot values
      enter(0, 2, 31, 24, 60, 99);
      check("sanitise", {12'd0, bin_time}, {12'd0, 12'd1, 8'd2, 8'd28, 8'd0, 8'd0, 8'd0});
      leave();
      enter(2022, 13, 0, 5, 6, 7);
      check("sanitise_m13", 64'(bin_time[39:24]), 64'h0101);
      leave();

      // same-cycle button priority
      enter(2021, 5, 30, 18, 32, 7);
      cycle(0, 1, 1, 0);
      check("sel_over_up_field", {61'd0, field}, 64'd1);
      check("sel_over_up_word", {12'd0, bin_time}, {12'd0, 12'd2021, 8'd5, 8'd30, 8'd18, 8'd32, 8'd7});
      cycle(1, 0, 1, 0);
      check("mode_over_up", {11'd0, set_time, bin_time}, {11'd0, 1'b1, 12'd2021, 8'd5, 8'd30, 8'd18, 8'd32, 8'd7});
      cycle(0, 0, 0, 0);

      // idle timeout abandons the edit
      enter(2030, 7, 4, 1, 2, 3);
      repeat (TO - 1) cycle(0, 0, 0, 0);
      check("timeout_not_yet", {63'd0, editing}, 64'd1);
      cycle(0, 0, 0, 0);
      check("timeout_exit", {63'd0, editing}, 64'd0);
      cycle(0, 0, 1, 0);

      // reset during COMMIT
      enter(2040, 8, 9, 10, 11, 12);
      cycle(1, 0, 0, 0);
      rst = 1'b1;
      #1;
      check("rst_commit_strobe", {63'd0, set_time}, 64'd0);
      check("rst_commit_word", {12'd0, bin_time}, {12'd0, 12'd2021, 8'd5, 8'd30, 8'd18, 8'd32, 8'd0});
      check("rst_commit_edit", {63'd0, editing}, 64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(0, 0, 1, 0);
      cycle(0, 1, 0, 0);

      // random stimulus against the reference model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            repeat (TO + 2) cycle(0, 0, 0, 0);
         end else begin
            set_cur($urandom_range(0, 4095), $urandom_range(0, 15), $urandom_range(0, 35),
                    $urandom_range(0, 30), $urandom_range(0, 70), $urandom_range(0, 70));
            cycle($urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
